// File: rtl/cabac_byte_feeder.sv
// ============================================================================
// Module   : cabac_byte_feeder
// Brief    : Byte FIFO feeding the CABAC decoder core. It strips
//            emulation-prevention bytes when CABAC_FEEDER_EPB_STRIP_EN is
//            defined and flags underflow for the top-level stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cabac_byte_feeder #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic          request_byte,
  output logic [7:0]    data,
  output logic          data_valid,
  output logic          underflow,
  output logic [CW-1:0] level
);

  localparam int            c_AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_rp;
  logic [c_AW-1:0] r_wp;
  logic [CW-1:0]   r_level;
  logic            r_data_valid;

  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_level_nxt;

  assign in_ready   = reset_n && !flush && (r_level < c_FULL);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_accept && !w_drop;
  // A request in the flush cycle is neither a pop nor an underflow.
  assign w_pop      = request_byte && r_data_valid && !flush;
  assign underflow  = reset_n && request_byte && !r_data_valid && !flush;

  assign data       = r_data_valid ? r_mem[r_rp] : 8'h00;
  assign data_valid = r_data_valid;
  assign level      = r_level;

`ifdef CABAC_FEEDER_EPB_STRIP_EN
  logic [1:0] r_zero_cnt;
  logic [1:0] w_zero_cnt_nxt;

  assign w_drop = (r_zero_cnt == 2'd2) && (in_data == 8'h03);

  always_comb begin
    w_zero_cnt_nxt = r_zero_cnt;
    if (w_accept) begin
      if (w_drop) begin
        w_zero_cnt_nxt = 2'd0;
      end else if (in_data == 8'h00) begin
        w_zero_cnt_nxt = (r_zero_cnt == 2'd2) ? 2'd2 : r_zero_cnt + 2'd1;
      end else begin
        w_zero_cnt_nxt = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zero_cnt <= 2'd0;
    end else if (flush) begin
      r_zero_cnt <= 2'd0;
    end else begin
      r_zero_cnt <= w_zero_cnt_nxt;
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage carries no reset; stale entries are masked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rp         <= '0;
      r_wp         <= '0;
      r_level      <= '0;
      r_data_valid <= 1'b0;
    end else if (flush) begin
      r_rp         <= '0;
      r_wp         <= '0;
      r_level      <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      r_level      <= w_level_nxt;
      r_data_valid <= (w_level_nxt != '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cabac_byte_feeder.sv
// ============================================================================
// Module   : tb_cabac_byte_feeder
// Brief    : Scoreboard bench for cabac_byte_feeder (DEPTH=8), covering the
//            default build and the CABAC_FEEDER_EPB_STRIP_EN build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cabac_byte_feeder;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       request_byte;
  logic [7:0] data;
  logic       data_valid;
  logic       underflow;
  logic [3:0] level;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];

  cabac_byte_feeder #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .request_byte (request_byte),
    .data         (data),
    .data_valid   (data_valid),
    .underflow    (underflow),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Every pop the decoder performs is checked against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && request_byte && data_valid && !flush) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %02h but no byte was expected", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL pop_data: got %02h expected %02h", data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rq, input logic fl);
    in_valid     = v;
    in_data      = d;
    request_byte = rq;
    flush        = fl;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic stored);
    drive(1'b1, d, 1'b0, 1'b0);
    if (stored) exp_q.push_back(d);
    settle();
    next_cycle();
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      settle();
      next_cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic strip;

  initial begin
    checks  = 0;
    errors  = 0;
`ifdef CABAC_FEEDER_EPB_STRIP_EN
    strip = 1'b1;
`else
    strip = 1'b0;
`endif
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    settle();
    chk("rst_level", level, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_underflow", underflow, 0);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    settle();
    chk("post_rst_in_ready", in_ready, 1);
    next_cycle();

    // Two pushes, no requests
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    exp_q.push_back(8'hA5);
    settle();
    next_cycle();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    settle();
    chk("first_valid", data_valid, 1);
    chk("first_data", data, 8'hA5);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("two_level", level, 2);
    chk("two_data", data, 8'hA5);
    next_cycle();
    drain(2);
    settle();
    chk("drained_level", level, 0);
    chk("drained_valid", data_valid, 0);
    next_cycle();

    // Fill to full, then pop/push around the wrap
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
    drive(1'b1, 8'h18, 1'b1, 1'b0);
    settle();
    chk("full_level", level, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_data", data, 8'h10);
    next_cycle();
    drive(1'b1, 8'h18, 1'b1, 1'b0);
    exp_q.push_back(8'h18);
    settle();
    chk("after_pop_level", level, 7);
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_data", data, 8'h11);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("pushpop_level", level, 7);
    chk("pushpop_data", data, 8'h12);
    next_cycle();
    drain(7);
    settle();
    chk("wrap_empty_level", level, 0);
    next_cycle();

    // Underflow with a concurrent push
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    settle();
    chk("uf_pulse", underflow, 1);
    chk("uf_level", level, 0);
    next_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("uf_clear", underflow, 0);
    chk("uf_push_level", level, 1);
    chk("uf_push_data", data, 8'h5A);
    next_cycle();
    drain(1);

    // Emulation-prevention sequence
    push_byte(8'h00, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h03, !strip);
    push_byte(8'h01, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h03, !strip);
    push_byte(8'h03, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("epb_level", level, strip ? 6 : 8);
    next_cycle();
    drain(strip ? 6 : 8);

    // Flush with request and push in the same cycle, zero history pending
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h00, 1'b1);
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    settle();
    chk("flush_in_ready", in_ready, 0);
    chk("flush_underflow", underflow, 0);
    next_cycle();
    exp_q.delete();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("flush_level", level, 0);
    chk("flush_valid", data_valid, 0);
    chk("flush_data", data, 0);
    next_cycle();
    push_byte(8'h03, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h00, 1'b1);
    push_byte(8'h03, !strip);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle();
    chk("post_flush_level", level, strip ? 3 : 4);
    chk("post_flush_data", data, 8'h03);
    next_cycle();
    drain(strip ? 3 : 4);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i), 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("burst_level", level, 5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", data_valid, 0);
    chk("arst_data", data, 0);
    chk("arst_in_ready", in_ready, 0);
    exp_q.delete();
    next_cycle();
    reset_n = 1'b1;
    settle();
    chk("arst_release_ready", in_ready, 1);
    chk("arst_release_level", level, 0);
    next_cycle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
